// File: rtl/lc3_kbd_rx.sv
// LC-3 keyboard receive front end: 8N1 serial receiver feeding a small byte FIFO
// whose head is presented as KBDR, with KBSR ready/overrun status.
module lc3_kbd_rx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxd,
    input  logic        kbdr_rd,
    input  logic        clr_overrun,
    output logic [15:0] kbdr,
    output logic        kb_ready,
    output logic        kb_overrun,
    output logic        frame_err
);
    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] RELOAD = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] HALF   = TW'(CLK_DIV / 2 - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic             rxd_m_q, rxd_s_q;
    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0] count_q, count_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];

    logic tick, push_req, pop, full, wr_en, drop;

    assign tick = (timer_q == '0);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        push_req    = 1'b0;
        if (state_q == S_IDLE) begin
            // First tick lands half a bit in, so every later sample is at a bit centre.
            timer_d = HALF;
            if (!rxd_s_q) state_d = S_START;
        end else begin
            timer_d = tick ? RELOAD : timer_q - 1'b1;
            if (tick) begin
                case (state_q)
                    S_START: begin
                        if (rxd_s_q) state_d = S_IDLE;
                        else begin
                            state_d   = S_DATA;
                            bit_idx_d = 3'd0;
                        end
                    end
                    S_DATA: begin
                        shreg_d[bit_idx_q] = rxd_s_q;
                        if (bit_idx_q == 3'd7) state_d = S_STOP;
                        else bit_idx_d = bit_idx_q + 3'd1;
                    end
                    default: begin
                        state_d = S_IDLE;
                        if (rxd_s_q) push_req = 1'b1;
                        else frame_err_d = 1'b1;
                    end
                endcase
            end
        end
    end

    assign pop   = kbdr_rd && (count_q != '0);
    assign full  = (count_q == FULL_CNT);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
    assign wr_en = push_req && (!full || pop);
    assign drop  = push_req && full && !pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = shreg_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overrun_d = drop ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rxd_m_q     <= rxd;
            rxd_s_q     <= rxd_m_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

    assign kb_ready   = (count_q != '0);
    assign kbdr       = {8'h00, kb_ready ? mem_q[rd_ptr_q] : 8'h00};
    assign kb_overrun = overrun_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_lc3_kbd_rx.sv
// Bench for lc3_kbd_rx: directed table, corner sequences and random frames vs a queue model.
module tb_lc3_kbd_rx;
    localparam int CLK_DIV = 16;
    localparam int FRAME   = 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd = 1'b1;
    logic        kbdr_rd = 1'b0;
    logic        clr_overrun = 1'b0;
    logic [15:0] kbdr;
    logic        kb_ready, kb_overrun, frame_err;

    int n_chk = 0;
    int n_fail = 0;

    lc3_kbd_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .kbdr_rd(kbdr_rd), .clr_overrun(clr_overrun),
        .kbdr(kbdr), .kb_ready(kb_ready), .kb_overrun(kb_overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic        exp_ready;
        logic [15:0] exp_kbdr;
        int          exp_ferr;
        logic        exp_ovr;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one 8N1 frame; rd_cyc>=0 raises kbdr_rd for that one cycle of the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_cyc,
                              output int first_rdy, output int ferr);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        first_rdy = -1;
        ferr = 0;
        for (int c = 0; c < FRAME; c++) begin
            rxd = bits[c / CLK_DIV];
            kbdr_rd = (c == rd_cyc);
            step();
            if (kb_ready && first_rdy < 0) first_rdy = c + 1;
            if (frame_err) ferr++;
        end
        rxd = 1'b1;
        kbdr_rd = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (frame_err) ferr++;
        end
    endtask

    task automatic do_read();
        kbdr_rd = 1'b1;
        step();
        kbdr_rd = 1'b0;
    endtask

    logic [7:0] q[$];
    logic       m_ovr;

    initial begin
        int fr, fe;
        logic [7:0] d;
        logic       st;
        int         nrd;

        vt[0] = '{8'hA5, 1'b0, 1'b0, 16'h0000, 1, 1'b0};
        vt[1] = '{8'h01, 1'b1, 1'b1, 16'h0001, 0, 1'b0};
        vt[2] = '{8'h02, 1'b1, 1'b1, 16'h0001, 0, 1'b0};
        vt[3] = '{8'h03, 1'b1, 1'b1, 16'h0001, 0, 1'b0};
        vt[4] = '{8'h04, 1'b1, 1'b1, 16'h0001, 0, 1'b0};
        vt[5] = '{8'h05, 1'b1, 1'b1, 16'h0001, 0, 1'b1};

        repeat (3) step();
        chk("rst_kbdr", 32'(kbdr), 0);
        chk("rst_ready", 32'(kb_ready), 0);
        chk("rst_ovr", 32'(kb_overrun), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        rst_n = 1'b1;
        step();

        // 2 sync + half-bit + 9 bit times after the start edge -> ready appears after edge 155.
        send_frame(8'h41, 1'b1, -1, fr, fe);
        chk("lat_first_ready", 32'(fr), 155);
        chk("lat_kbdr", 32'(kbdr), 32'h0041);
        chk("lat_ferr", 32'(fe), 0);
        do_read();
        chk("rd41_ready", 32'(kb_ready), 0);
        chk("rd41_kbdr", 32'(kbdr), 0);

        foreach (vt[i]) begin
            send_frame(vt[i].data, vt[i].stop, -1, fr, fe);
            chk($sformatf("vec%0d_ready", i), 32'(kb_ready), 32'(vt[i].exp_ready));
            chk($sformatf("vec%0d_kbdr", i), 32'(kbdr), 32'(vt[i].exp_kbdr));
            chk($sformatf("vec%0d_ferr", i), 32'(fe), 32'(vt[i].exp_ferr));
            chk($sformatf("vec%0d_ovr", i), 32'(kb_overrun), 32'(vt[i].exp_ovr));
        end
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain%0d", i), 32'(kbdr), 32'(i));
            do_read();
        end
        chk("drain_ready", 32'(kb_ready), 0);
        chk("drain_kbdr", 32'(kbdr), 0);
        do_read();
        chk("pop_empty_ready", 32'(kb_ready), 0);
        chk("ovr_sticky", 32'(kb_overrun), 1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        chk("ovr_clr", 32'(kb_overrun), 0);

        // Start glitch: 3 low cycles then idle.
        fe = 0;
        rxd = 1'b0;
        repeat (3) step();
        rxd = 1'b1;
        for (int c = 0; c < 3 * CLK_DIV; c++) begin
            step();
            if (frame_err) fe++;
        end
        chk("glitch_ready", 32'(kb_ready), 0);
        chk("glitch_ferr", 32'(fe), 0);
        send_frame(8'h5A, 1'b1, -1, fr, fe);
        chk("post_glitch_kbdr", 32'(kbdr), 32'h005A);
        do_read();

        // Push and pop on the same edge with one entry held.
        send_frame(8'h10, 1'b1, -1, fr, fe);
        chk("pp_pre", 32'(kbdr), 32'h0010);
        send_frame(8'h20, 1'b1, 154, fr, fe);
        chk("pp_kbdr", 32'(kbdr), 32'h0020);
        chk("pp_ready", 32'(kb_ready), 1);
        do_read();
        chk("pp_count1", 32'(kb_ready), 0);

        // Reset in data bit 3, with a byte already buffered.
        send_frame(8'h33, 1'b1, -1, fr, fe);
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'h7E, 1'b0};
            for (int c = 0; c < 4 * CLK_DIV - 8; c++) begin
                rxd = bits[c / CLK_DIV];
                step();
            end
        end
        rst_n = 1'b0;
        rxd = 1'b1;
        step();
        chk("midrst_kbdr", 32'(kbdr), 0);
        chk("midrst_ready", 32'(kb_ready), 0);
        chk("midrst_ovr", 32'(kb_overrun), 0);
        rst_n = 1'b1;
        repeat (2) step();
        send_frame(8'h7E, 1'b1, -1, fr, fe);
        chk("midrst_7e", 32'(kbdr), 32'h007E);
        do_read();
        chk("midrst_empty", 32'(kb_ready), 0);

        // Random frames against a byte-queue model of the FIFO.
        q.delete();
        m_ovr = 1'b0;
        for (int it = 0; it < 24; it++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 5) != 0);
            send_frame(d, st, -1, fr, fe);
            if (st) begin
                if (q.size() < 4) q.push_back(d);
                else m_ovr = 1'b1;
            end
            chk($sformatf("rnd%0d_ferr", it), 32'(fe), st ? 0 : 1);
            chk($sformatf("rnd%0d_ready", it), 32'(kb_ready), 32'(q.size() != 0));
            chk($sformatf("rnd%0d_kbdr", it), 32'(kbdr), (q.size() != 0) ? 32'(q[0]) : 0);
            chk($sformatf("rnd%0d_ovr", it), 32'(kb_overrun), 32'(m_ovr));
            nrd = $urandom_range(0, 2);
            for (int r = 0; r < nrd; r++) begin
                do_read();
                if (q.size() != 0) void'(q.pop_front());
                chk($sformatf("rnd%0d_rd%0d", it, r), 32'(kbdr), (q.size() != 0) ? 32'(q[0]) : 0);
            end
            if ($urandom_range(0, 3) == 0) begin
                clr_overrun = 1'b1;
                step();
                clr_overrun = 1'b0;
                m_ovr = 1'b0;
                chk($sformatf("rnd%0d_clr", it), 32'(kb_overrun), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
